bsort_ctrl: RTL
===============

Name: bsort_ctrl

Overview:
Sequencing controller for the bubble-sort engine. It drives the nested outer-pass and inner-index loops over a window [lb, ub] of an external register array and issues compare/swap read and write transactions. Each pass shrinks the window by one, and the sort terminates early after any pass that performs no swap. It sits between the sort top level (start/done handshake) and the data register file (two combinational read ports, one dual-write port).

Parameters:
DW, 8, data word width (unsigned compare)
AW, 4, index/address width; window bounds and addresses are AW bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to sort; sampled only in IDLE
lb  in  AW  lower window index, latched on accepted start
ub  in  AW  upper window index (inclusive), latched on accepted start
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse when the sort completes
addr_a  out  AW  read/write address of left element (= j)
addr_b  out  AW  read/write address of right element (= j+1, modulo 2^AW)
rd_a  in  DW  combinational read data at addr_a
rd_b  in  DW  combinational read data at addr_b
we  out  1  write strobe; writes wd_a->addr_a and wd_b->addr_b in the same cycle
wd_a  out  DW  data written to addr_a
wd_b  out  DW  data written to addr_b
swaps  out  8  number of swaps in the current/last sort; saturates at 255; cleared on accepted start

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, j=0, last=0, swapped=0. Outputs: busy=0, done=0, we=0, wd_a=wd_b=0, swaps=0, addr_a=0, addr_b=1. Reset wins over every other event, including mid-swap. No write may occur in the cycle after reset.
- Internal registers: j (inner index), last (current pass end), lo (latched lb), swapped (pass flag), tmp_a and tmp_b (latched read data).
- IDLE:
  - start=1: latch lo=lb, clear swaps.
  - If ub<=lb: go to DONE.
  - Otherwise: j=lb, last=ub, swapped=0, go to CMP.
- CMP (one cycle per index):
  - addr_a=j, addr_b=j+1.
  - If rd_a>rd_b (unsigned): tmp_a=rd_a, tmp_b=rd_b, go to SWAP.
  - Otherwise apply the ADVANCE rule.
  - Equal values never swap (stable).
- SWAP (one cycle):
  - we=1, wd_a=tmp_b, wd_b=tmp_a, at the same addresses as the preceding CMP.
  - Set swapped=1; swaps increments, saturating at 255.
  - Then apply the ADVANCE rule. The swapped value used by ADVANCE includes this swap.
- ADVANCE rule (evaluated on leaving CMP or SWAP):
  - If j+1 < last: j=j+1, stay in or return to CMP.
  - Otherwise the pass ends:
    - If swapped=0, or last-1==lo: go to DONE.
    - Else: last=last-1, j=lo, swapped=0, go to CMP.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- start while busy: ignored; lb and ub are not re-latched.
- we is high only in SWAP; wd_a and wd_b hold their last value otherwise.
- Latency from the start edge: a sorted window of n elements finishes at edge n-1 (done high for the following cycle). Each swap adds one cycle.
- Widths: j+1 and last-1 are computed in AW bits. Bounds guarantee no wrap during operation, since j+1<=ub<=2^AW-1.

Decomposition:
- Shared package bsort_pkg holds:
  - state typedef (IDLE, CMP, SWAP, DONE)
  - default DW and AW constants
  - SWAP_CNT_W = 8
- Natural sub-module: bsort_idx_cnt, the inner-index counter with load/increment/terminal-compare. It is reused for outer `last` with a decrement mode.
- The FSM and swap datapath stay in bsort_ctrl.

Test Plan:
1. Memory [1,2,3,4], lb=0, ub=3, start at edge 0 -> CMP j=0,1,2; we never high; done high between edges 3 and 4; swaps=0.
2. Memory [4,3,2,1], lb=0, ub=3 -> exactly 6 we pulses at (0,1),(1,2),(2,3),(0,1),(1,2),(0,1); final [1,2,3,4]; swaps=6; done once.
3. lb=5, ub=5 (and lb=7, ub=2) -> no CMP, no we; done high between edges 0 and 1; busy=1 only in that cycle.
4. Memory [2,2,1,1], lb=0, ub=3 -> equal pairs never swapped; final [1,1,2,2]; swaps=4.
5. start re-pulsed while busy with different lb/ub -> ignored; result and swaps match the original request.
6. rst asserted in a SWAP cycle -> next cycle state IDLE, we=0, busy=0, done=0, swaps=0; a fresh start then sorts correctly.

Source files
------------

// File: rtl/bsort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsort_pkg
//  Description : Shared types and constants for the bubble-sort controller.
//                Holds the controller state encoding, the default data and
//                address widths, and the width of the swap counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsort_pkg;

    localparam int DW_DEF     = 8;   // default data word width
    localparam int AW_DEF     = 4;   // default index/address width
    localparam int SWAP_CNT_W = 8;   // swap counter width (saturating)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_SWAP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : bsort_pkg
`default_nettype wire

// File: rtl/bsort_idx_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : bsort_idx_cnt
//  Description : Loadable up/down index counter with a terminal compare.
//                Up mode   : term = !(cnt+1 < bound)  (inner index reached end)
//                Down mode : term =  (cnt-1 == bound) (outer pass end reached lo)
//                Load has priority over step. All arithmetic is AW bits.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                load, load_val - synchronous load
//                step           - advance by one in the configured direction
//                bound          - compare operand for the terminal flag
//                cnt            - current count
//                term           - terminal condition (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module bsort_idx_cnt #(
    parameter int             AW      = 4,
    parameter bit             DEC     = 1'b0,
    parameter logic [AW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          step,
    input  logic [AW-1:0] bound,
    output logic [AW-1:0] cnt,
    output logic          term
);

    logic [AW-1:0] w_cnt_next;

    generate
        if (DEC) begin : g_dec
            assign w_cnt_next = cnt - AW'(1);
            assign term       = (w_cnt_next == bound);
        end else begin : g_inc
            assign w_cnt_next = cnt + AW'(1);
            assign term       = !(w_cnt_next < bound);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (step) begin
            cnt <= w_cnt_next;
        end
    end

endmodule : bsort_idx_cnt
`default_nettype wire

// File: rtl/bsort_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bsort_ctrl
//  Description : Sequencing controller for the bubble-sort engine. Walks the
//                inner index j over [lo, last) comparing (j, j+1), issues a
//                one-cycle swap write when the left element is larger, and
//                shrinks the window by one after every pass. Stops early after
//                a pass without swaps.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start, lb, ub   - sort request and inclusive window bounds
//                busy, done      - status / one-cycle completion pulse
//                addr_a, addr_b  - left/right element addresses (j, j+1)
//                rd_a, rd_b      - combinational read data from the reg file
//                we, wd_a, wd_b  - dual write strobe and data
//                swaps           - saturating swap count of the current sort
//  Revision    : 1.0 - initial release
// ============================================================================
module bsort_ctrl
    import bsort_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         lb,
    input  logic [AW-1:0]         ub,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         addr_a,
    output logic [AW-1:0]         addr_b,
    input  logic [DW-1:0]         rd_a,
    input  logic [DW-1:0]         rd_b,
    output logic                  we,
    output logic [DW-1:0]         wd_a,
    output logic [DW-1:0]         wd_b,
    output logic [SWAP_CNT_W-1:0] swaps
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_j;
    logic [AW-1:0]         r_last;
    logic [AW-1:0]         r_lo;
    logic                  r_swapped;
    logic [DW-1:0]         r_tmp_a;
    logic [DW-1:0]         r_tmp_b;
    logic [SWAP_CNT_W-1:0] r_swaps;

    // Control strobes from the next-state logic
    logic                  w_j_load;
    logic [AW-1:0]         w_j_load_val;
    logic                  w_j_step;
    logic                  w_j_term;
    logic                  w_last_load;
    logic                  w_last_step;
    logic                  w_last_term;
    logic                  w_lo_load;
    logic                  w_swaps_clr;
    logic                  w_swaps_inc;
    logic                  w_tmp_load;
    logic                  w_sw_set;
    logic                  w_sw_clr;
    logic                  w_adv;
    logic                  w_sw_eff;

    // ------------------------------------------------------------------
    // Inner index j: terminal when j+1 is no longer below last
    // ------------------------------------------------------------------
    bsort_idx_cnt #(
        .AW      (AW),
        .DEC     (1'b0),
        .RST_VAL ('0)
    ) u_j_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_j_load),
        .load_val (w_j_load_val),
        .step     (w_j_step),
        .bound    (r_last),
        .cnt      (r_j),
        .term     (w_j_term)
    );

    // ------------------------------------------------------------------
    // Outer pass end `last`: terminal when last-1 reaches lo, i.e. the
    // next pass would contain a single element and cannot swap anything
    // ------------------------------------------------------------------
    bsort_idx_cnt #(
        .AW      (AW),
        .DEC     (1'b1),
        .RST_VAL ('0)
    ) u_last_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_last_load),
        .load_val (ub),
        .step     (w_last_step),
        .bound    (r_lo),
        .cnt      (r_last),
        .term     (w_last_term)
    );

    // The swap happening this cycle counts towards the pass flag
    assign w_sw_eff = r_swapped | (r_state == ST_SWAP);

    // ------------------------------------------------------------------
    // Next-state / control logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_j_load     = 1'b0;
        w_j_load_val = r_lo;
        w_j_step     = 1'b0;
        w_last_load  = 1'b0;
        w_last_step  = 1'b0;
        w_lo_load    = 1'b0;
        w_swaps_clr  = 1'b0;
        w_swaps_inc  = 1'b0;
        w_tmp_load   = 1'b0;
        w_sw_set     = 1'b0;
        w_sw_clr     = 1'b0;
        w_adv        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_lo_load   = 1'b1;
                    w_swaps_clr = 1'b1;
                    if (ub <= lb) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_j_load     = 1'b1;
                        w_j_load_val = lb;
                        w_last_load  = 1'b1;
                        w_sw_clr     = 1'b1;
                        w_state_nxt  = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                // Strict compare keeps equal elements in place
                if (rd_a > rd_b) begin
                    w_tmp_load  = 1'b1;
                    w_state_nxt = ST_SWAP;
                end else begin
                    w_adv = 1'b1;
                end
            end
            ST_SWAP: begin
                w_sw_set    = 1'b1;
                w_swaps_inc = 1'b1;
                w_adv       = 1'b1;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Advance: next index, next pass, or finish
        if (w_adv) begin
            if (!w_j_term) begin
                w_j_step    = 1'b1;
                w_state_nxt = ST_CMP;
            end else if (!w_sw_eff || w_last_term) begin
                w_state_nxt = ST_DONE;
            end else begin
                w_last_step  = 1'b1;
                w_j_load     = 1'b1;
                w_j_load_val = r_lo;
                w_sw_clr     = 1'b1;
                w_state_nxt  = ST_CMP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lo      <= '0;
            r_swapped <= 1'b0;
            r_tmp_a   <= '0;
            r_tmp_b   <= '0;
            r_swaps   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_lo_load) begin
                r_lo <= lb;
            end

            // A pass restart clears the flag even when leaving a swap
            if (w_sw_clr) begin
                r_swapped <= 1'b0;
            end else if (w_sw_set) begin
                r_swapped <= 1'b1;
            end

            if (w_tmp_load) begin
                r_tmp_a <= rd_a;
                r_tmp_b <= rd_b;
            end

            if (w_swaps_clr) begin
                r_swaps <= '0;
            end else if (w_swaps_inc && (r_swaps != '1)) begin
                r_swaps <= r_swaps + SWAP_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Write data comes straight from the latched read data, so
    // it holds its last value whenever no swap is in progress.
    // ------------------------------------------------------------------
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign we     = (r_state == ST_SWAP);
    assign addr_a = r_j;
    assign addr_b = r_j + AW'(1);
    assign wd_a   = r_tmp_b;
    assign wd_b   = r_tmp_a;
    assign swaps  = r_swaps;

endmodule : bsort_ctrl
`default_nettype wire
